// File: rtl/tlb_unit_pkg.sv
// Shared MMU/CP0 types: CP0 register layouts, TLB entry record and
// translation result record used by the joint TLB.
package tlb_unit_pkg;

  localparam int         TLB_ENTRIES = 8;
  localparam int         IDX_W       = 3;
  localparam logic [2:0] CCA_CACHED  = 3'b011;

  // CP0 EntryHi: VPN2 in [31:13], ASID in [7:0]
  typedef struct packed {
    logic [18:0] vpn2;
    logic [4:0]  zero;
    logic [7:0]  asid;
  } EntryHi_t;

  // CP0 EntryLo0/EntryLo1: PFN in [25:6], C/D/V/G below it
  typedef struct packed {
    logic [5:0]  zero;
    logic [19:0] pfn;
    logic [2:0]  c;
    logic        d;
    logic        v;
    logic        g;
  } EntryLo_t;

  // CP0 Index: probe-failure bit P on top, entry index at the bottom
  typedef struct packed {
    logic                 p;
    logic [30-IDX_W:0]    zero;
    logic [IDX_W-1:0]     index;
  } Index_t;

  // CP0 Random: replacement index at the bottom
  typedef struct packed {
    logic [31-IDX_W:0]    zero;
    logic [IDX_W-1:0]     random;
  } Random_t;

  // One TLB entry: a shared VPN2/ASID/G tag and an even/odd page pair
  typedef struct packed {
    logic [18:0] vpn2;
    logic [7:0]  asid;
    logic        g;
    logic [19:0] pfn0;
    logic [2:0]  c0;
    logic        d0;
    logic        v0;
    logic [19:0] pfn1;
    logic [2:0]  c1;
    logic        d1;
    logic        v1;
  } TLBEntry_t;

  // Translation outcome for one lookup port
  typedef struct packed {
    logic [31:0] paddr;
    logic        cached;
    logic        refill;
    logic        invalid;
    logic        modified;
  } xlate_t;

endpackage

// File: rtl/tlb_unit_match.sv
// Fully associative tag compare with lowest-index priority encode.
// Pure combinational; one copy per lookup port plus one for probe.
module tlb_match
  import tlb_unit_pkg::*;
#(
  parameter int N = TLB_ENTRIES,
  parameter int W = IDX_W
) (
  input  logic [N-1:0][18:0] vpn2_tab,
  input  logic [N-1:0][7:0]  asid_tab,
  input  logic [N-1:0]       g_tab,
  input  logic [18:0]        vpn2,
  input  logic [7:0]         asid,
  output logic               hit,
  output logic [W-1:0]       idx
);

  // Walk from the top entry down so the lowest matching index is kept last
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int e = N - 1; e >= 0; e--) begin
      if (vpn2_tab[e] == vpn2 && (g_tab[e] || asid_tab[e] == asid)) begin
        hit = 1'b1;
        idx = W'(e);
      end
    end
  end

endmodule

// File: rtl/tlb_unit.sv
// Joint instruction/data TLB beside CP0: TLBWI/TLBWR writes, TLBP probe,
// TLBR read-back and two independent single-cycle address translations.
module tlb_unit #(
  parameter int TLB_ENTRIES = 8,
  parameter int IDX_W       = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] EntryHi,
  input  logic [31:0] EntryLo0,
  input  logic [31:0] EntryLo1,
  input  logic [31:0] Index,
  input  logic [31:0] Random,
  input  logic [2:0]  K0,
  input  logic        tlbwi,
  input  logic        tlbwr,
  input  logic        tlbp,
  output logic [31:0] tlb_EntryHi,
  output logic [31:0] tlb_EntryLo0,
  output logic [31:0] tlb_EntryLo1,
  output logic [31:0] tlb_Index,
  input  logic        i_req,
  input  logic [31:0] i_vaddr,
  output logic        i_valid,
  output logic [31:0] i_paddr,
  output logic        i_cached,
  output logic        i_refill,
  output logic        i_invalid,
  input  logic        d_req,
  input  logic [31:0] d_vaddr,
  input  logic        d_we,
  output logic        d_valid,
  output logic [31:0] d_paddr,
  output logic        d_cached,
  output logic        d_refill,
  output logic        d_invalid,
  output logic        d_modified
);

  import tlb_unit_pkg::*;

  // Fault priority is refill > invalid > modified; any fault zeroes paddr/cached.
  function automatic xlate_t translate(input TLBEntry_t  e,
                                       input logic       hit,
                                       input logic [31:0] va,
                                       input logic [2:0] k0,
                                       input logic       we);
    xlate_t      r;
    logic [19:0] pfn;
    logic [2:0]  c;
    logic        d;
    logic        v;
    r   = '0;
    pfn = va[12] ? e.pfn1 : e.pfn0;
    c   = va[12] ? e.c1   : e.c0;
    d   = va[12] ? e.d1   : e.d0;
    v   = va[12] ? e.v1   : e.v0;
    if (va[31:30] == 2'b10) begin
      r.paddr  = {3'b000, va[28:0]};
      r.cached = ~va[29] & (k0 == CCA_CACHED);
    end else if (!hit) begin
      r.refill = 1'b1;
    end else if (!v) begin
      r.invalid = 1'b1;
    end else if (we && !d) begin
      r.modified = 1'b1;
    end else begin
      r.paddr  = {pfn, va[11:0]};
      r.cached = (c == CCA_CACHED);
    end
    return r;
  endfunction

  EntryHi_t  hi;
  EntryLo_t  lo0;
  EntryLo_t  lo1;
  TLBEntry_t new_entry;
  TLBEntry_t rd_entry;
  TLBEntry_t entries [TLB_ENTRIES];

  logic [TLB_ENTRIES-1:0][18:0] vpn2_tab;
  logic [TLB_ENTRIES-1:0][7:0]  asid_tab;
  logic [TLB_ENTRIES-1:0]       g_tab;

  logic             i_hit, d_hit, p_hit;
  logic [IDX_W-1:0] i_idx, d_idx, p_idx;
  xlate_t           i_res_p0, d_res_p0;
  logic             unused_bits;

  assign hi  = EntryHi;
  assign lo0 = EntryLo0;
  assign lo1 = EntryLo1;

  // Upper register bits carry no TLB state
  assign unused_bits = ^{hi.zero, lo0.zero, lo1.zero,
                         Index[31:IDX_W], Random[31:IDX_W]};

  // Assemble the entry image that a TLBWI/TLBWR would store
  always_comb begin
    new_entry      = '0;
    new_entry.vpn2 = hi.vpn2;
    new_entry.asid = hi.asid;
    new_entry.g    = lo0.g & lo1.g;
    new_entry.pfn0 = lo0.pfn;
    new_entry.c0   = lo0.c;
    new_entry.d0   = lo0.d;
    new_entry.v0   = lo0.v;
    new_entry.pfn1 = lo1.pfn;
    new_entry.c1   = lo1.c;
    new_entry.d1   = lo1.d;
    new_entry.v1   = lo1.v;
  end

  // Entry array: TLBWI has priority over TLBWR; reset clears every entry
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int e = 0; e < TLB_ENTRIES; e++) entries[e] <= '0;
    end else if (tlbwi) begin
      entries[Index[IDX_W-1:0]] <= new_entry;
    end else if (tlbwr) begin
      entries[Random[IDX_W-1:0]] <= new_entry;
    end
  end

  // Flatten tag fields for the matchers
  always_comb begin
    vpn2_tab = '0;
    asid_tab = '0;
    g_tab    = '0;
    for (int e = 0; e < TLB_ENTRIES; e++) begin
      vpn2_tab[e] = entries[e].vpn2;
      asid_tab[e] = entries[e].asid;
      g_tab[e]    = entries[e].g;
    end
  end

  tlb_match #(.N(TLB_ENTRIES), .W(IDX_W)) u_match_i (
    .vpn2_tab (vpn2_tab),
    .asid_tab (asid_tab),
    .g_tab    (g_tab),
    .vpn2     (i_vaddr[31:13]),
    .asid     (hi.asid),
    .hit      (i_hit),
    .idx      (i_idx)
  );

  tlb_match #(.N(TLB_ENTRIES), .W(IDX_W)) u_match_d (
    .vpn2_tab (vpn2_tab),
    .asid_tab (asid_tab),
    .g_tab    (g_tab),
    .vpn2     (d_vaddr[31:13]),
    .asid     (hi.asid),
    .hit      (d_hit),
    .idx      (d_idx)
  );

  tlb_match #(.N(TLB_ENTRIES), .W(IDX_W)) u_match_p (
    .vpn2_tab (vpn2_tab),
    .asid_tab (asid_tab),
    .g_tab    (g_tab),
    .vpn2     (hi.vpn2),
    .asid     (hi.asid),
    .hit      (p_hit),
    .idx      (p_idx)
  );

  // Probe result and TLBR read-back, both from pre-write contents
  always_comb begin
    rd_entry     = entries[Index[IDX_W-1:0]];
    tlb_EntryHi  = {rd_entry.vpn2, 5'b0, rd_entry.asid};
    tlb_EntryLo0 = {6'b0, rd_entry.pfn0, rd_entry.c0, rd_entry.d0, rd_entry.v0, rd_entry.g};
    tlb_EntryLo1 = {6'b0, rd_entry.pfn1, rd_entry.c1, rd_entry.d1, rd_entry.v1, rd_entry.g};
    tlb_Index    = '0;
    if (tlbp) begin
      tlb_Index = p_hit ? {{(32-IDX_W){1'b0}}, p_idx} : 32'h8000_0000;
    end
  end

  // Stage p0: combinational translation of both ports
  always_comb begin
    i_res_p0 = translate(entries[i_idx], i_hit, i_vaddr, K0, 1'b0);
    d_res_p0 = translate(entries[d_idx], d_hit, d_vaddr, K0, d_we);
  end

  // Stage p1: register results; fields hold when no request is issued
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      i_valid    <= 1'b0;
      i_paddr    <= '0;
      i_cached   <= 1'b0;
      i_refill   <= 1'b0;
      i_invalid  <= 1'b0;
      d_valid    <= 1'b0;
      d_paddr    <= '0;
      d_cached   <= 1'b0;
      d_refill   <= 1'b0;
      d_invalid  <= 1'b0;
      d_modified <= 1'b0;
    end else begin
      i_valid <= i_req;
      d_valid <= d_req;
      if (i_req) begin
        i_paddr   <= i_res_p0.paddr;
        i_cached  <= i_res_p0.cached;
        i_refill  <= i_res_p0.refill;
        i_invalid <= i_res_p0.invalid;
      end
      if (d_req) begin
        d_paddr    <= d_res_p0.paddr;
        d_cached   <= d_res_p0.cached;
        d_refill   <= d_res_p0.refill;
        d_invalid  <= d_res_p0.invalid;
        d_modified <= d_res_p0.modified;
      end
    end
  end

endmodule

// File: tb/tb_tlb_unit.sv
// Self-checking bench for tlb_unit: directed vector table, hand-written
// hazard sequences, then randomized traffic against a behavioural model.
module tb_tlb_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] EntryHi, EntryLo0, EntryLo1, Index, Random;
  logic [2:0]  K0;
  logic        tlbwi, tlbwr, tlbp;
  logic [31:0] tlb_EntryHi, tlb_EntryLo0, tlb_EntryLo1, tlb_Index;
  logic        i_req, i_valid, i_cached, i_refill, i_invalid;
  logic [31:0] i_vaddr, i_paddr;
  logic        d_req, d_we, d_valid, d_cached, d_refill, d_invalid, d_modified;
  logic [31:0] d_vaddr, d_paddr;

  always #5 clk = ~clk;

  tlb_unit dut (
    .clk(clk), .rst_n(rst_n),
    .EntryHi(EntryHi), .EntryLo0(EntryLo0), .EntryLo1(EntryLo1),
    .Index(Index), .Random(Random), .K0(K0),
    .tlbwi(tlbwi), .tlbwr(tlbwr), .tlbp(tlbp),
    .tlb_EntryHi(tlb_EntryHi), .tlb_EntryLo0(tlb_EntryLo0),
    .tlb_EntryLo1(tlb_EntryLo1), .tlb_Index(tlb_Index),
    .i_req(i_req), .i_vaddr(i_vaddr), .i_valid(i_valid), .i_paddr(i_paddr),
    .i_cached(i_cached), .i_refill(i_refill), .i_invalid(i_invalid),
    .d_req(d_req), .d_vaddr(d_vaddr), .d_we(d_we), .d_valid(d_valid),
    .d_paddr(d_paddr), .d_cached(d_cached), .d_refill(d_refill),
    .d_invalid(d_invalid), .d_modified(d_modified)
  );

  typedef struct packed {
    logic [31:0] paddr;
    logic        cached;
    logic        refill;
    logic        invalid;
    logic        modified;
  } res_t;

  typedef struct {
    bit          dside;
    logic [31:0] va;
    bit          we;
    logic [2:0]  k0;
    res_t        exp;
  } vec_t;

  int passed = 0;
  int total  = 0;

  // Behavioural model of the entry array
  logic [18:0] m_vpn2 [8];
  logic [7:0]  m_asid [8];
  logic        m_g    [8];
  logic [19:0] m_pfn  [8][2];
  logic [2:0]  m_c    [8][2];
  logic        m_d    [8][2];
  logic        m_v    [8][2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic void m_reset();
    for (int e = 0; e < 8; e++) begin
      m_vpn2[e] = '0; m_asid[e] = '0; m_g[e] = 1'b0;
      for (int p = 0; p < 2; p++) begin
        m_pfn[e][p] = '0; m_c[e][p] = '0; m_d[e][p] = 1'b0; m_v[e][p] = 1'b0;
      end
    end
  endfunction

  function automatic void m_write(input int idx, input logic [31:0] hi,
                                  input logic [31:0] l0, input logic [31:0] l1);
    logic [31:0] lo;
    m_vpn2[idx] = hi[31:13];
    m_asid[idx] = hi[7:0];
    m_g[idx]    = l0[0] & l1[0];
    for (int p = 0; p < 2; p++) begin
      lo = (p == 0) ? l0 : l1;
      m_pfn[idx][p] = lo[25:6];
      m_c[idx][p]   = lo[5:3];
      m_d[idx][p]   = lo[2];
      m_v[idx][p]   = lo[1];
    end
  endfunction

  function automatic int m_find(input logic [18:0] vpn2, input logic [7:0] asid);
    for (int e = 0; e < 8; e++)
      if (m_vpn2[e] == vpn2 && (m_g[e] || m_asid[e] == asid)) return e;
    return -1;
  endfunction

  function automatic logic [31:0] m_probe(input logic [31:0] hi);
    int e;
    e = m_find(hi[31:13], hi[7:0]);
    return (e < 0) ? 32'h8000_0000 : 32'(e);
  endfunction

  function automatic res_t m_xlate(input logic [31:0] va, input bit we,
                                   input logic [7:0] asid, input logic [2:0] k0);
    res_t r;
    int   e;
    int   pg;
    r = '0;
    if (va[31:30] == 2'b10) begin
      r.paddr  = va & 32'h1FFF_FFFF;
      r.cached = (va[29] == 1'b0) && (k0 == 3'd3);
      return r;
    end
    e  = m_find(va[31:13], asid);
    pg = int'(va[12]);
    if (e < 0) r.refill = 1'b1;
    else if (!m_v[e][pg]) r.invalid = 1'b1;
    else if (we && !m_d[e][pg]) r.modified = 1'b1;
    else begin
      r.paddr  = {m_pfn[e][pg], 12'h000} | {20'h0, va[11:0]};
      r.cached = (m_c[e][pg] == 3'd3);
    end
    return r;
  endfunction

  task automatic check_i(input string tag, input logic vld, input res_t e);
    check({tag, ".i_valid"},   i_valid,   vld);
    check({tag, ".i_paddr"},   i_paddr,   e.paddr);
    check({tag, ".i_cached"},  i_cached,  e.cached);
    check({tag, ".i_refill"},  i_refill,  e.refill);
    check({tag, ".i_invalid"}, i_invalid, e.invalid);
  endtask

  task automatic check_d(input string tag, input logic vld, input res_t e);
    check({tag, ".d_valid"},    d_valid,    vld);
    check({tag, ".d_paddr"},    d_paddr,    e.paddr);
    check({tag, ".d_cached"},   d_cached,   e.cached);
    check({tag, ".d_refill"},   d_refill,   e.refill);
    check({tag, ".d_invalid"},  d_invalid,  e.invalid);
    check({tag, ".d_modified"}, d_modified, e.modified);
  endtask

  task automatic tlb_wi(input logic [31:0] idx, input logic [31:0] hi,
                        input logic [31:0] l0, input logic [31:0] l1);
    EntryHi = hi; EntryLo0 = l0; EntryLo1 = l1; Index = idx; tlbwi = 1'b1;
    step();
    tlbwi = 1'b0;
    m_write(int'(idx[2:0]), hi, l0, l1);
  endtask

  task automatic lookup(input bit dside, input logic [31:0] va, input bit we);
    if (dside) begin d_req = 1'b1; d_vaddr = va; d_we = we; end
    else begin i_req = 1'b1; i_vaddr = va; end
    step();
    i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
  endtask

  vec_t        vecs [9];
  res_t        exp_i, exp_d, r0;
  logic        exp_iv, exp_dv;
  logic [18:0] pool [4];

  initial begin
    // Directed vectors with entry 3 = {VPN2 0x200, ASID 5, page0 PFN 0x12345 C=3 D=1 V=1, page1 V=0}
    vecs[0] = '{1'b1, 32'h0040_0abc, 1'b0, 3'd3, '{32'h1234_5abc, 1'b1, 1'b0, 1'b0, 1'b0}};
    vecs[1] = '{1'b1, 32'h0040_1000, 1'b0, 3'd3, '{32'h0,         1'b0, 1'b0, 1'b1, 1'b0}};
    vecs[2] = '{1'b0, 32'h0040_0abc, 1'b0, 3'd3, '{32'h1234_5abc, 1'b1, 1'b0, 1'b0, 1'b0}};
    vecs[3] = '{1'b0, 32'h8000_1000, 1'b0, 3'd3, '{32'h0000_1000, 1'b1, 1'b0, 1'b0, 1'b0}};
    vecs[4] = '{1'b1, 32'hA000_1000, 1'b0, 3'd3, '{32'h0000_1000, 1'b0, 1'b0, 1'b0, 1'b0}};
    vecs[5] = '{1'b1, 32'h0040_0000, 1'b1, 3'd3, '{32'h1234_5000, 1'b1, 1'b0, 1'b0, 1'b0}};
    vecs[6] = '{1'b0, 32'h0060_0000, 1'b0, 3'd3, '{32'h0,         1'b0, 1'b1, 1'b0, 1'b0}};
    vecs[7] = '{1'b1, 32'h8000_1000, 1'b1, 3'd3, '{32'h0000_1000, 1'b1, 1'b0, 1'b0, 1'b0}};
    vecs[8] = '{1'b0, 32'h8000_1000, 1'b0, 3'd2, '{32'h0000_1000, 1'b0, 1'b0, 1'b0, 1'b0}};
    pool[0] = 19'h00200; pool[1] = 19'h00201; pool[2] = 19'h7FF00; pool[3] = 19'h00000;
    r0 = '0;

    rst_n = 1'b0; EntryHi = '0; EntryLo0 = '0; EntryLo1 = '0; Index = '0; Random = '0;
    K0 = 3'd3; tlbwi = 1'b0; tlbwr = 1'b0; tlbp = 1'b0;
    i_req = 1'b0; i_vaddr = '0; d_req = 1'b0; d_vaddr = '0; d_we = 1'b0;
    m_reset();
    step(); step();
    check_i("reset", 1'b0, r0);
    check_d("reset", 1'b0, r0);
    rst_n = 1'b1;

    // 1. Probe miss after reset, refill on mapped fetch
    EntryHi = 32'h0000_2000; tlbp = 1'b1; #1;
    check("t1.probe_miss", tlb_Index, 32'h8000_0000);
    tlbp = 1'b0;
    lookup(1'b0, 32'h0040_0000, 1'b0);
    check_i("t1.refill", 1'b1, '{32'h0, 1'b0, 1'b1, 1'b0, 1'b0});
    step();
    check("t1.valid_drop", i_valid, 1'b0);
    check("t1.refill_hold", i_refill, 1'b1);

    // 2/5. Write entry 3 and run the vector table
    tlb_wi(32'd3, 32'h0040_0005, 32'h0048_D15E, 32'h0000_0000);
    for (int n = 0; n < 9; n++) begin
      K0 = vecs[n].k0;
      lookup(vecs[n].dside, vecs[n].va, vecs[n].we);
      if (vecs[n].dside) check_d($sformatf("vec%0d", n), 1'b1, vecs[n].exp);
      else               check_i($sformatf("vec%0d", n), 1'b1, vecs[n].exp);
    end
    K0 = 3'd3;

    // 3. Clean page: store faults, load translates
    tlb_wi(32'd3, 32'h0040_0005, 32'h0048_D15A, 32'h0000_0000);
    lookup(1'b1, 32'h0040_0000, 1'b1);
    check_d("t3.store", 1'b1, '{32'h0, 1'b0, 1'b0, 1'b0, 1'b1});
    lookup(1'b1, 32'h0040_0000, 1'b0);
    check_d("t3.load", 1'b1, '{32'h1234_5000, 1'b1, 1'b0, 1'b0, 1'b0});

    // 4. ASID mismatch refills, global entry hits any ASID
    EntryHi = 32'h0040_0006;
    lookup(1'b1, 32'h0040_0abc, 1'b0);
    check_d("t4.asid_miss", 1'b1, '{32'h0, 1'b0, 1'b1, 1'b0, 1'b0});
    tlb_wi(32'd3, 32'h0040_0005, 32'h0048_D15F, 32'h0000_0001);
    EntryHi = 32'h0040_0006;
    lookup(1'b1, 32'h0040_0abc, 1'b0);
    check_d("t4.global_hit", 1'b1, '{32'h1234_5abc, 1'b1, 1'b0, 1'b0, 1'b0});
    tlbp = 1'b1; Index = 32'd3; #1;
    check("t4.probe", tlb_Index, 32'd3);
    check("t4.tlbr_hi", tlb_EntryHi, 32'h0040_0005);
    check("t4.tlbr_lo0", tlb_EntryLo0, 32'h0048_D15F);
    check("t4.tlbr_lo1", tlb_EntryLo1, 32'h0000_0001);
    tlbp = 1'b0;

    // 6a. TLBWI and TLBWR together: only the Index slot changes
    EntryHi = 32'h00C0_0007; EntryLo0 = 32'h0000_0006; EntryLo1 = 32'h0000_0002;
    Index = 32'd5; Random = 32'd6; tlbwi = 1'b1; tlbwr = 1'b1;
    step();
    tlbwi = 1'b0; tlbwr = 1'b0;
    m_write(5, 32'h00C0_0007, 32'h0000_0006, 32'h0000_0002);
    #1;
    check("t6.wi_slot", tlb_EntryHi, 32'h00C0_0007);
    check("t6.wi_lo0", tlb_EntryLo0, 32'h0000_0006);
    Index = 32'd6; #1;
    check("t6.wr_slot", tlb_EntryHi, 32'h0);
    check("t6.wr_lo0", tlb_EntryLo0, 32'h0);

    // 6b. Write with same-cycle probe and lookup sees old contents
    EntryHi = 32'h0060_0005; EntryLo0 = 32'h0000_0002; EntryLo1 = 32'h0000_0002;
    Index = 32'd2; tlbwi = 1'b1; tlbp = 1'b1; d_req = 1'b1; d_vaddr = 32'h0060_0000; #1;
    check("t6.probe_old", tlb_Index, 32'h8000_0000);
    step();
    tlbwi = 1'b0; d_req = 1'b0;
    m_write(2, 32'h0060_0005, 32'h0000_0002, 32'h0000_0002);
    check_d("t6.lookup_old", 1'b1, '{32'h0, 1'b0, 1'b1, 1'b0, 1'b0});
    check("t6.probe_new", tlb_Index, 32'd2);
    tlbp = 1'b0;
    lookup(1'b1, 32'h0060_0123, 1'b0);
    check_d("t6.lookup_new", 1'b1, '{32'h0000_0123, 1'b0, 1'b0, 1'b0, 1'b0});

    // 6c. Reset while a fetch is in flight drops it
    i_req = 1'b1; i_vaddr = 32'h8000_1000; rst_n = 1'b0;
    step();
    check_i("t6.rst_drop", 1'b0, r0);
    i_req = 1'b0; rst_n = 1'b1; m_reset();
    exp_i = '0; exp_d = '0;

    // Randomized traffic: writes, probes, reads, lookups all at once
    for (int n = 0; n < 400; n++) begin
      EntryHi  = {pool[$urandom_range(0, 3)], 5'($urandom), 8'($urandom_range(0, 1))};
      EntryLo0 = $urandom; EntryLo1 = $urandom;
      if ($urandom_range(0, 1) == 1) EntryLo0[5:3] = 3'd3;
      Index = $urandom; Random = $urandom;
      tlbwi = ($urandom_range(0, 3) == 0); tlbwr = ($urandom_range(0, 3) == 0);
      tlbp = 1'b1; K0 = 3'($urandom);
      i_req = 1'($urandom); d_req = 1'($urandom); d_we = 1'($urandom);
      i_vaddr = {pool[$urandom_range(0, 3)], 13'($urandom)};
      d_vaddr = {pool[$urandom_range(0, 3)], 13'($urandom)};
      if ($urandom_range(0, 4) == 0) i_vaddr[31:30] = 2'b10;
      if ($urandom_range(0, 4) == 0) d_vaddr[31:30] = 2'b10;
      #1;
      check("rnd.probe", tlb_Index, m_probe(EntryHi));
      check("rnd.tlbr_hi", tlb_EntryHi,
            {m_vpn2[Index[2:0]], 5'b0, m_asid[Index[2:0]]});
      check("rnd.tlbr_lo1", tlb_EntryLo1,
            {6'b0, m_pfn[Index[2:0]][1], m_c[Index[2:0]][1], m_d[Index[2:0]][1],
             m_v[Index[2:0]][1], m_g[Index[2:0]]});
      exp_iv = i_req; exp_dv = d_req;
      if (i_req) exp_i = m_xlate(i_vaddr, 1'b0, EntryHi[7:0], K0);
      if (d_req) exp_d = m_xlate(d_vaddr, d_we, EntryHi[7:0], K0);
      if (tlbwi)      m_write(int'(Index[2:0]),  EntryHi, EntryLo0, EntryLo1);
      else if (tlbwr) m_write(int'(Random[2:0]), EntryHi, EntryLo0, EntryLo1);
      step();
      check_i("rnd", exp_iv, exp_i);
      check_d("rnd", exp_dv, exp_d);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
